// File: rtl/mac_result_drain.sv
// Result drain for mac_array: captures a complete set of four accumulators, requantizes
// each lane (rounding shift, optional ReLU, saturation) and streams them out one per transfer.
module mac_result_drain #(
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int N_MACS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [ACC_W-1:0] acc_in_0,
    input  logic signed [ACC_W-1:0] acc_in_1,
    input  logic signed [ACC_W-1:0] acc_in_2,
    input  logic signed [ACC_W-1:0] acc_in_3,
    input  logic [N_MACS-1:0]       acc_valid,
    input  logic [3:0]              shift,
    input  logic                    relu_en,
    output logic [N_MACS-1:0]       clear,
    output logic signed [OUT_W-1:0] out_data,
    output logic [1:0]              out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [1:0]              LAST_IDX = 2'(N_MACS - 1);
    localparam logic signed [ACC_W:0]   OUT_MAX  = $signed((ACC_W + 1)'(2 ** (OUT_W - 1) - 1));
    localparam logic signed [ACC_W:0]   OUT_MIN  = ~OUT_MAX;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [ACC_W-1:0] acc,
        input logic [3:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W:0] v;
        logic [ACC_W:0]        rnd;
        v   = {acc[ACC_W-1], acc};
        rnd = '0;
        if (sh != 4'd0) begin
            rnd = (ACC_W + 1)'(1) << (sh - 4'd1);
        end
        v = v + $signed(rnd);
        v = v >>> sh;
        if (relu && v[ACC_W]) begin
            v = '0;
        end
        if (v > OUT_MAX) begin
            v = OUT_MAX;
        end else if (v < OUT_MIN) begin
            v = OUT_MIN;
        end
        return v[OUT_W-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic [N_MACS-1:0]       clear_q, clear_d;
    logic                    overrun_q, overrun_d;
    logic signed [OUT_W-1:0] lane_q [N_MACS];
    logic signed [OUT_W-1:0] lane_d [N_MACS];
    logic signed [ACC_W-1:0] acc_arr [N_MACS];

    logic set_full;
    logic xfer;
    logic capture;

    assign acc_arr[0] = acc_in_0;
    assign acc_arr[1] = acc_in_1;
    assign acc_arr[2] = acc_in_2;
    assign acc_arr[3] = acc_in_3;

    assign set_full = &acc_valid;
    assign xfer     = (state_q == DRAIN) && out_ready;

    always_comb begin
        for (int i = 0; i < N_MACS; i++) begin
            lane_d[i] = requant(acc_arr[i], shift, relu_en);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        clear_d    = '0;
        overrun_d  = overrun_q;
        capture    = 1'b0;

        case (state_q)
            IDLE: begin
                if (set_full) begin
                    capture = 1'b1;
                end
            end
            DRAIN: begin
                if (xfer && out_last_q) begin
                    if (set_full) begin
                        capture = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        idx_d      = '0;
                        out_data_d = '0;
                        out_last_d = 1'b0;
                    end
                end else begin
                    if (xfer) begin
                        idx_d      = idx_q + 2'd1;
                        out_data_d = lane_q[idx_q + 2'd1];
                        out_last_d = ((idx_q + 2'd1) == LAST_IDX);
                    end
                    // A full set arriving mid-drain is dropped and remembered as overrun.
                    if (set_full) begin
                        overrun_d = 1'b1;
                    end
                end
            end
        endcase

        if (capture) begin
            state_d    = DRAIN;
            idx_d      = '0;
            out_data_d = lane_d[0];
            out_last_d = 1'b0;
            clear_d    = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            clear_q    <= '0;
            overrun_q  <= 1'b0;
            // NOTE: the lane store is only four words, so it is reset like any other register.
            for (int i = 0; i < N_MACS; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            clear_q    <= clear_d;
            overrun_q  <= overrun_d;
            if (capture) begin
                for (int i = 0; i < N_MACS; i++) begin
                    lane_q[i] <= lane_d[i];
                end
            end
        end
    end

    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_last  = out_last_q;
    assign clear     = clear_q;
    assign overrun   = overrun_q;

endmodule
